// File: rtl/mig_stream_sequencer_if.sv
// mig_stream_sequencer_if
// Bundles every non-clock/reset signal of the stream sequencer: MIG UI command and
// write-data channels, MIG read return, input FIFO head/pop and output FIFO push.
// Modports:
//   master - the sequencer (drives app_*, ib_re, ob_we, ob_data)
//   slave  - the environment (MIG, FIFOs, enables)
interface mig_stream_sequencer_if;
   // Control
   logic         calib_done;
   logic         writes_en;
   logic         reads_en;
   // Input FIFO (first-word-fall-through)
   logic [127:0] ib_data;
   logic [7:0]   ib_count;
   logic         ib_empty;
   logic         ib_re;
   // Output FIFO
   logic [7:0]   ob_count;
   logic         ob_full;
   logic         ob_we;
   logic [127:0] ob_data;
   // MIG UI
   logic         app_rdy;
   logic         app_wdf_rdy;
   logic         app_rd_data_valid;
   logic [127:0] app_rd_data;
   logic         app_en;
   logic         app_wdf_wren;
   logic         app_wdf_end;
   logic [2:0]   app_cmd;
   logic [27:0]  app_addr;
   logic [127:0] app_wdf_data;
   logic [15:0]  app_wdf_mask;

   modport master (
      input  calib_done, writes_en, reads_en,
      input  ib_data, ib_count, ib_empty,
      output ib_re,
      input  ob_count, ob_full,
      output ob_we, ob_data,
      input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
      output app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr, app_wdf_data, app_wdf_mask
   );

   modport slave (
      output calib_done, writes_en, reads_en,
      output ib_data, ib_count, ib_empty,
      input  ib_re,
      output ob_count, ob_full,
      input  ob_we, ob_data,
      output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
      input  app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr, app_wdf_data, app_wdf_mask
   );
endinterface

// File: rtl/mig_stream_sequencer.sv
// mig_stream_sequencer
// Moves 128-bit words between a pair of stream FIFOs and a MIG user interface in
// bursts of BURST_WORDS. Write bursts pop the input FIFO into DDR, read bursts issue
// read commands whose returned data is forwarded to the output FIFO. Write and read
// bursts share the UI and are arbitrated round-robin when both are eligible.
// Ports:
//   clk   - MIG ui_clk, sole clock
//   rst_n - asynchronous active-low reset
//   bus   - mig_stream_sequencer_if.master (MIG UI, FIFO and enable signals)
module mig_stream_sequencer #(
   parameter int unsigned BURST_WORDS  = 32,
   parameter logic [27:0] ADDR_STEP    = 28'd8,
   parameter logic [27:0] ADDR_LIMIT   = 28'h3FF_FFF8,
   parameter int unsigned OB_MAX_COUNT = 191
) (
   input logic                   clk,
   input logic                   rst_n,
   mig_stream_sequencer_if.master bus
);

   typedef enum logic [1:0] {StIdle, StWrData, StWrCmd, StRdCmd} state_e;

   state_e       state_q, state_d;
   logic [5:0]   beat_q, beat_d;
   logic [27:0]  wr_ptr_q, wr_ptr_d;
   logic [27:0]  rd_ptr_q, rd_ptr_d;
   logic         last_wr_q, last_wr_d;  // 1: the most recently started burst was a write
   logic         ob_we_q;
   logic [127:0] ob_data_q;

   logic         wr_elig, rd_elig, last_beat;
   logic         app_en, app_wdf_wren, ib_re;
   logic [2:0]   app_cmd;
   logic [27:0]  app_addr;
   logic [127:0] app_wdf_data;

   // Output FIFO headroom is guaranteed by OB_MAX_COUNT, so the full flag is not needed.
   logic unused_ob_full;
   assign unused_ob_full = bus.ob_full;

   function automatic logic [27:0] ptr_adv(input logic [27:0] p);
      return (p == ADDR_LIMIT) ? 28'd0 : p + ADDR_STEP;
   endfunction

   assign wr_elig   = bus.writes_en && (32'(bus.ib_count) >= BURST_WORDS);
   assign rd_elig   = bus.reads_en && (32'(bus.ob_count) <= OB_MAX_COUNT);
   assign last_beat = (32'(beat_q) == BURST_WORDS - 32'd1);

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      last_wr_d    = last_wr_q;
      app_en       = 1'b0;
      app_cmd      = 3'b000;
      app_addr     = 28'd0;
      app_wdf_wren = 1'b0;
      app_wdf_data = 128'd0;
      ib_re        = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Enables are only sampled here, so dropping them mid-burst never aborts one.
            if (bus.calib_done) begin
               if (wr_elig && (!rd_elig || !last_wr_q)) begin
                  state_d   = StWrData;
                  beat_d    = 6'd0;
                  last_wr_d = 1'b1;
               end else if (rd_elig) begin
                  state_d   = StRdCmd;
                  beat_d    = 6'd0;
                  last_wr_d = 1'b0;
               end
            end
         end
         StWrData: begin
            app_addr = wr_ptr_q;
            if (bus.app_wdf_rdy && !bus.ib_empty) begin
               app_wdf_wren = 1'b1;
               app_wdf_data = bus.ib_data;
               ib_re        = 1'b1;
               state_d      = StWrCmd;
            end
         end
         StWrCmd: begin
            app_en   = 1'b1;
            app_cmd  = 3'b000;
            app_addr = wr_ptr_q;
            if (bus.app_rdy) begin
               wr_ptr_d = ptr_adv(wr_ptr_q);
               beat_d   = beat_q + 6'd1;
               state_d  = last_beat ? StIdle : StWrData;
            end
         end
         StRdCmd: begin
            app_en   = 1'b1;
            app_cmd  = 3'b001;
            app_addr = rd_ptr_q;
            if (bus.app_rdy) begin
               rd_ptr_d = ptr_adv(rd_ptr_q);
               beat_d   = beat_q + 6'd1;
               if (last_beat) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         beat_q    <= 6'd0;
         wr_ptr_q  <= 28'd0;
         rd_ptr_q  <= 28'd0;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         last_wr_q <= last_wr_d;
      end
   end

   // Read return path: plain one-cycle register, independent of the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ob_we_q   <= 1'b0;
         ob_data_q <= 128'd0;
      end else begin
         ob_we_q   <= bus.app_rd_data_valid;
         ob_data_q <= bus.app_rd_data;
      end
   end

   assign bus.app_en       = app_en;
   assign bus.app_cmd      = app_cmd;
   assign bus.app_addr     = app_addr;
   assign bus.app_wdf_wren = app_wdf_wren;
   assign bus.app_wdf_end  = app_wdf_wren;  // one wdf beat per 128-bit word
   assign bus.app_wdf_data = app_wdf_data;
   assign bus.app_wdf_mask = 16'h0000;
   assign bus.ib_re        = ib_re;
   assign bus.ob_we        = ob_we_q;
   assign bus.ob_data      = ob_data_q;

endmodule

// File: tb/tb_mig_stream_sequencer.sv
module tb_mig_stream_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         calib_done, calib_l, writes_en, reads_en, ib_empty, ob_full;
   logic         app_rdy, app_wdf_rdy, app_rd_data_valid;
   logic [127:0] ib_data, app_rd_data;
   logic [7:0]   ib_count, ob_count;

   mig_stream_sequencer_if bus ();
   mig_stream_sequencer_if bus_l ();

   assign bus.calib_done          = calib_done;
   assign bus.writes_en           = writes_en;
   assign bus.reads_en            = reads_en;
   assign bus.ib_data             = ib_data;
   assign bus.ib_count            = ib_count;
   assign bus.ib_empty            = ib_empty;
   assign bus.ob_count            = ob_count;
   assign bus.ob_full             = ob_full;
   assign bus.app_rdy             = app_rdy;
   assign bus.app_wdf_rdy         = app_wdf_rdy;
   assign bus.app_rd_data_valid   = app_rd_data_valid;
   assign bus.app_rd_data         = app_rd_data;
   assign bus_l.calib_done        = calib_l;
   assign bus_l.writes_en         = writes_en;
   assign bus_l.reads_en          = reads_en;
   assign bus_l.ib_data           = ib_data;
   assign bus_l.ib_count          = ib_count;
   assign bus_l.ib_empty          = ib_empty;
   assign bus_l.ob_count          = ob_count;
   assign bus_l.ob_full           = ob_full;
   assign bus_l.app_rdy           = app_rdy;
   assign bus_l.app_wdf_rdy       = app_wdf_rdy;
   assign bus_l.app_rd_data_valid = app_rd_data_valid;
   assign bus_l.app_rd_data       = app_rd_data;

   mig_stream_sequencer u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mig_stream_sequencer #(
      .ADDR_LIMIT (28'd248)
   ) u_dut_lim (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_l)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state
   logic [2:0]   q_cmd[$];
   logic [27:0]  q_addr[$];
   logic [27:0]  wp, rp, hold_addr;
   logic [2:0]   hold_cmd;
   logic         prev_pend, prev_valid;
   logic [127:0] prev_data;
   int           n_acc, n_wbeat, n_wacc, n_ibre, first_wren, n_en;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] next_addr(input logic [27:0] a, input logic [27:0] lim);
      return (a == lim) ? 28'd0 : a + 28'd8;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_app_en"}, 128'(bus.app_en), 128'd0);
      chk({tag, "_wren"}, 128'(bus.app_wdf_wren), 128'd0);
      chk({tag, "_wend"}, 128'(bus.app_wdf_end), 128'd0);
      chk({tag, "_ib_re"}, 128'(bus.ib_re), 128'd0);
      chk({tag, "_ob_we"}, 128'(bus.ob_we), 128'd0);
      chk({tag, "_cmd"}, 128'(bus.app_cmd), 128'd0);
      chk({tag, "_addr"}, 128'(bus.app_addr), 128'd0);
      chk({tag, "_wdata"}, bus.app_wdf_data, 128'd0);
      chk({tag, "_odata"}, bus.ob_data, 128'd0);
      chk({tag, "_mask"}, 128'(bus.app_wdf_mask), 128'd0);
   endtask

   // Reset held for two cycles, released at a falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      calib_done = 1'b0; calib_l = 1'b0; writes_en = 1'b0; reads_en = 1'b0;
      ib_empty = 1'b0; ob_full = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      app_rd_data_valid = 1'b1; app_rd_data = {4{32'hDEADBEEF}};
      ib_data = '0; ib_count = 8'd0; ob_count = 8'd0;

      // Reset values, with read data valid driven to prove ob_we is held low.
      #2;
      chk_zero("reset");
      app_rd_data_valid = 1'b0;

      // Not calibrated: no command despite write eligibility.
      do_reset();
      writes_en = 1'b1; ib_count = 8'd200; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      n_en = 0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (bus.app_en || bus.app_wdf_wren) n_en++;
         @(negedge clk);
      end
      chk("nocal_app_en", 128'(n_en), 128'd0);

      // Single write burst, UI always ready; writes_en dropped after the start.
      do_reset();
      calib_done = 1'b1;
      n_acc = 0; n_wbeat = 0; n_ibre = 0; first_wren = -1;
      for (int c = 0; c < 90; c++) begin
         if (c == 1) writes_en = 1'b0;
         ib_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         if (bus.app_wdf_wren) begin
            if (first_wren < 0) first_wren = c;
            n_wbeat++;
            chk("wr_wdata", bus.app_wdf_data, ib_data);
         end
         if (bus.ib_re) n_ibre++;
         if (bus.app_en && app_rdy) begin
            chk("wr_cmd", 128'(bus.app_cmd), 128'd0);
            chk("wr_addr", 128'(bus.app_addr), 128'(n_acc * 8));
            n_acc++;
         end
         @(negedge clk);
      end
      #1;
      chk("wr_first_beat_cycle", 128'(first_wren), 128'd1);
      chk("wr_beats", 128'(n_wbeat), 128'd32);
      chk("wr_cmds", 128'(n_acc), 128'd32);
      chk("wr_ib_re", 128'(n_ibre), 128'd32);
      chk("wr_idle_en", 128'(bus.app_en), 128'd0);
      chk("wr_idle_addr", 128'(bus.app_addr), 128'd0);

      // Both eligible, randomized UI/FIFO readiness: W,R,W,R,W,R command stream.
      q_cmd.delete(); q_addr.delete();
      wp = 28'd0; rp = 28'd0;
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 32; i++) begin
            if (b % 2 == 0) begin
               q_cmd.push_back(3'b000); q_addr.push_back(wp); wp = next_addr(wp, 28'h3FF_FFF8);
            end else begin
               q_cmd.push_back(3'b001); q_addr.push_back(rp); rp = next_addr(rp, 28'h3FF_FFF8);
            end
         end
      end
      do_reset();
      writes_en = 1'b1; reads_en = 1'b1;
      n_acc = 0; n_wbeat = 0; n_wacc = 0; prev_pend = 1'b0;
      hold_addr = '0; hold_cmd = '0;
      for (int c = 0; c < 4000 && q_cmd.size() > 0; c++) begin
         app_rdy     = ($urandom_range(0, 3) != 0);
         app_wdf_rdy = ($urandom_range(0, 3) != 0);
         ib_empty    = ($urandom_range(0, 7) == 0);
         ib_data     = {$urandom, $urandom, $urandom, $urandom};
         ib_count    = 8'($urandom_range(32, 255));
         ob_count    = 8'($urandom_range(0, 191));
         #1;
         if (prev_pend) begin
            chk("rr_hold_en", 128'(bus.app_en), 128'd1);
            chk("rr_hold_cmd", 128'(bus.app_cmd), 128'(hold_cmd));
            chk("rr_hold_addr", 128'(bus.app_addr), 128'(hold_addr));
         end
         if (ib_empty) chk("rr_no_wren_empty", 128'(bus.app_wdf_wren), 128'd0);
         if (bus.app_wdf_wren) begin
            n_wbeat++;
            chk("rr_wdata", bus.app_wdf_data, ib_data);
            chk("rr_ib_re", 128'(bus.ib_re), 128'd1);
            chk("rr_wend", 128'(bus.app_wdf_end), 128'd1);
         end
         if (bus.app_en && app_rdy) begin
            chk("rr_cmd", 128'(bus.app_cmd), 128'(q_cmd[0]));
            chk("rr_addr", 128'(bus.app_addr), 128'(q_addr[0]));
            if (q_cmd[0] == 3'b000) begin
               n_wacc++;
               chk("rr_wdf_before_cmd", 128'(n_wbeat), 128'(n_wacc));
            end
            void'(q_cmd.pop_front());
            void'(q_addr.pop_front());
            n_acc++;
         end
         prev_pend = bus.app_en && !app_rdy;
         hold_addr = bus.app_addr;
         hold_cmd  = bus.app_cmd;
         @(negedge clk);
      end
      chk("rr_accepts", 128'(n_acc), 128'd192);
      ib_empty = 1'b0; ib_count = 8'd200; ob_count = 8'd0;

      // Small ADDR_LIMIT instance: address after 248 wraps to 0.
      do_reset();
      calib_done = 1'b0; calib_l = 1'b1; writes_en = 1'b1; reads_en = 1'b0;
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      wp = 28'd0; n_acc = 0;
      for (int c = 0; c < 200 && n_acc < 33; c++) begin
         #1;
         if (bus_l.app_en && app_rdy) begin
            chk("lim_addr", 128'(bus_l.app_addr), 128'(wp));
            wp = next_addr(wp, 28'd248);
            n_acc++;
         end
         @(negedge clk);
      end
      chk("lim_accepts", 128'(n_acc), 128'd33);
      calib_l = 1'b0; writes_en = 1'b0;

      // Read command stalled for 10 cycles, then one accept.
      do_reset();
      calib_done = 1'b1; reads_en = 1'b1; ob_count = 8'd100; app_rdy = 1'b0;
      for (int c = 0; c < 14; c++) begin
         app_rdy = (c == 11);
         if (c == 2) reads_en = 1'b0;
         #1;
         if (c >= 1 && c <= 11) begin
            chk("stall_en", 128'(bus.app_en), 128'd1);
            chk("stall_cmd", 128'(bus.app_cmd), 128'd1);
            chk("stall_addr", 128'(bus.app_addr), 128'd0);
         end
         if (c == 12) begin
            chk("stall_next_en", 128'(bus.app_en), 128'd1);
            chk("stall_next_addr", 128'(bus.app_addr), 128'd8);
         end
         @(negedge clk);
      end

      // Read return pipeline: random traffic plus a directed 0xA5 pulse.
      do_reset();
      calib_done = 1'b0; reads_en = 1'b0; writes_en = 1'b0;
      prev_valid = 1'b0; prev_data = '0;
      for (int c = 0; c < 40; c++) begin
         if (c == 5) begin
            app_rd_data_valid = 1'b1; app_rd_data = {16{8'hA5}};
         end else if (c == 6) begin
            app_rd_data_valid = 1'b0; app_rd_data = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            app_rd_data_valid = 1'($urandom_range(0, 1));
            app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
         end
         #1;
         chk("ob_we", 128'(bus.ob_we), 128'(prev_valid));
         chk("ob_data", bus.ob_data, prev_data);
         prev_valid = app_rd_data_valid;
         prev_data  = app_rd_data;
         @(negedge clk);
      end

      // Reset mid write burst: outputs drop at once, no command after release.
      calib_done = 1'b1; writes_en = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      ib_empty = 1'b0; app_rd_data_valid = 1'b1;
      for (int c = 0; c < 10; c++) @(negedge clk);
      #1;
      chk("mid_burst_active", 128'(bus.app_en | bus.app_wdf_wren), 128'd1);
      rst_n = 1'b0;
      #1;
      chk_zero("mid_reset");
      writes_en = 1'b0; app_rd_data_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_en = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bus.app_en) n_en++;
         @(negedge clk);
      end
      chk("post_reset_no_en", 128'(n_en), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
